fetch_queue: RTL and testbench

//  Parametrised decoupling FIFO between the IF stage and the if2id register. Replaces the single-entry

---
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through decoupling FIFO between IF and the
// if2id register. Each entry carries {pc, instr, except, delayslot}. A flush
// can optionally keep the oldest entry that is still queued, so that a branch
// delay slot survives a branch-redirect flush.
module fetch_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 32,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned EXC_W   = 8,
   parameter int unsigned AFULL   = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         keep_head_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [PC_W-1:0]              in_pc_i,
   input  logic [INSTR_W-1:0]           in_instr_i,
   input  logic [EXC_W-1:0]             in_except_i,
   input  logic                         in_delayslot_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [PC_W-1:0]              out_pc_o,
   output logic [INSTR_W-1:0]           out_instr_o,
   output logic [EXC_W-1:0]             out_except_o,
   output logic                         out_delayslot_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         afull_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
   localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [EXC_W-1:0]   except;
      logic               delayslot;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           in_entry;
   entry_t           head;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_left;
   logic             push;
   logic             pop;
   logic             keep_ok;

   // Handshake, head selection and flush-survivor bookkeeping
   always_comb begin
      in_ready_o  = rst && (count < FULL_CNT);
      out_valid_o = rst && (count != '0);
      push        = in_valid_i && in_ready_o && !flush_i;
      pop         = out_valid_o && out_ready_i;
      // Survivor of a keep-head flush is the entry behind anything popped now
      rd_next     = rd_ptr + PTR_W'(pop);
      count_left  = count - CNT_W'(pop);
      keep_ok     = (count_left != '0);

      in_entry.pc        = in_pc_i;
      in_entry.instr     = in_instr_i;
      in_entry.except    = in_except_i;
      in_entry.delayslot = in_delayslot_i;

      head            = out_valid_o ? mem[rd_ptr] : '0;
      out_pc_o        = head.pc;
      out_instr_o     = head.instr;
      out_except_o    = head.except;
      out_delayslot_o = head.delayslot;

      count_o = count;
      afull_o = rst && (count >= AFULL_CNT);
   end

   // Pointer and occupancy update; flush overrides push
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         if (keep_head_i && keep_ok) begin
            rd_ptr <= rd_next;
            wr_ptr <= rd_next + ONE_PTR;
            count  <= ONE_CNT;
         end else begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE_PTR;
         if (pop)  rd_ptr <= rd_next;
         if (push && !pop)      count <= count + ONE_CNT;
         else if (pop && !push) count <= count - ONE_CNT;
      end
   end

   // Entry storage; contents are not cleared by reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_entry;
   end

   // Structural guarantees: no push into full, no pop from empty
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(push && (count == FULL_CNT)));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
      !(pop && (count == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4, AFULL=3).
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        keep_head_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_pc_i;
   logic [31:0] in_instr_i;
   logic [7:0]  in_except_i;
   logic        in_delayslot_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_pc_o;
   logic [31:0] out_instr_o;
   logic [7:0]  out_except_o;
   logic        out_delayslot_o;
   logic [2:0]  count_o;
   logic        afull_o;

   int n_cmp = 0;
   int n_err = 0;

   fetch_queue #(
      .DEPTH(4), .PC_W(32), .INSTR_W(32), .EXC_W(8), .AFULL(3)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .keep_head_i(keep_head_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
      .in_instr_i(in_instr_i), .in_except_i(in_except_i),
      .in_delayslot_i(in_delayslot_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
      .out_except_o(out_except_o), .out_delayslot_o(out_delayslot_o),
      .count_o(count_o), .afull_o(afull_o)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] exp_instr(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]};
   endfunction

   function automatic logic [7:0] exp_exc(input logic [31:0] pc);
      return pc[9:2];
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid_i     = v;
      in_pc_i        = pc;
      in_instr_i     = exp_instr(pc);
      in_except_i    = exp_exc(pc);
      in_delayslot_i = pc[2];
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check_eq({tag, "_valid"}, out_valid_o, 1'b1);
      check_eq({tag, "_pc"}, out_pc_o, pc);
      check_eq({tag, "_instr"}, out_instr_o, exp_instr(pc));
      check_eq({tag, "_exc"}, out_except_o, exp_exc(pc));
      check_eq({tag, "_ds"}, out_delayslot_o, pc[2]);
   endtask

   task automatic push_n(input logic [31:0] base, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         drive(1'b1, base + 32'(4 * i));
         tick();
      end
      drive(1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b0; flush_i = 1'b0; keep_head_i = 1'b0; out_ready_i = 1'b0;
      drive(1'b1, 32'h0000_0F00);

      // 1: reset held three cycles with in_valid asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_in_ready", in_ready_o, 1'b0);
         check_eq("rst_out_valid", out_valid_o, 1'b0);
         check_eq("rst_count", count_o, 3'd0);
         check_eq("rst_afull", afull_o, 1'b0);
         check_eq("rst_out_pc", out_pc_o, 32'h0);
      end
      drive(1'b0, 32'h0);
      rst = 1'b1;
      tick();
      check_eq("rel_in_ready", in_ready_o, 1'b1);
      check_eq("rel_count", count_o, 3'd0);
      check_eq("rel_out_valid", out_valid_o, 1'b0);

      // 2: fill to DEPTH with no consumer, then drain in order
      for (int unsigned i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i));
         tick();
         check_eq("fill_count", count_o, 3'(i + 1));
         check_eq("fill_afull", afull_o, (i + 1) >= 3);
         check_eq("fill_in_ready", in_ready_o, (i + 1) < 4);
      end
      drive(1'b1, 32'h1F0);
      tick();
      check_eq("full_hold_count", count_o, 3'd4);
      drive(1'b0, 32'h0);
      out_ready_i = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         check_head("drain", 32'h100 + 32'(4 * i));
         tick();
      end
      out_ready_i = 1'b0;
      check_eq("drain_valid", out_valid_o, 1'b0);
      check_eq("drain_count", count_o, 3'd0);
      check_eq("drain_pc_zero", out_pc_o, 32'h0);
      check_eq("drain_afull", afull_o, 1'b0);

      // 3: ten pushes with continuous pop across pointer wrap
      out_ready_i = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i));
         if (i > 0) check_eq("wrap_pc", out_pc_o, 32'h300 + 32'(4 * (i - 1)));
         tick();
         check_eq("wrap_count", count_o, 3'd1);
      end
      drive(1'b0, 32'h0);
      check_head("wrap_last", 32'h324);
      tick();
      out_ready_i = 1'b0;
      check_eq("wrap_empty", count_o, 3'd0);

      // 4: plain flush drops queue and the same-cycle push
      push_n(32'h400, 3);
      check_eq("fl_pre_count", count_o, 3'd3);
      flush_i = 1'b1; keep_head_i = 1'b0;
      drive(1'b1, 32'h40C);
      tick();
      flush_i = 1'b0;
      drive(1'b0, 32'h0);
      check_eq("fl_count", count_o, 3'd0);
      check_eq("fl_valid", out_valid_o, 1'b0);
      push_n(32'h500, 1);
      check_eq("fl_refill_count", count_o, 3'd1);
      check_head("fl_refill", 32'h500);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      // 5a: keep-head flush with a same-cycle pop
      push_n(32'h200, 3);
      flush_i = 1'b1; keep_head_i = 1'b1; out_ready_i = 1'b1;
      drive(1'b1, 32'h20C);
      tick();
      flush_i = 1'b0; keep_head_i = 1'b0; out_ready_i = 1'b0;
      drive(1'b0, 32'h0);
      check_eq("keep_pop_count", count_o, 3'd1);
      check_head("keep_pop", 32'h204);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      check_eq("keep_pop_drained", count_o, 3'd0);

      // 5b: keep-head flush without pop, then new push lands behind survivor
      push_n(32'h200, 3);
      flush_i = 1'b1; keep_head_i = 1'b1;
      tick();
      flush_i = 1'b0; keep_head_i = 1'b0;
      check_eq("keep_count", count_o, 3'd1);
      check_head("keep", 32'h200);
      push_n(32'h210, 1);
      check_eq("keep_push_count", count_o, 3'd2);
      out_ready_i = 1'b1;
      check_head("keep_seq0", 32'h200);
      tick();
      check_head("keep_seq1", 32'h210);
      tick();
      out_ready_i = 1'b0;
      check_eq("keep_seq_empty", out_valid_o, 1'b0);

      // 6: keep-head flush on a single entry that is popped the same cycle
      push_n(32'h600, 1);
      check_eq("single_pre", count_o, 3'd1);
      flush_i = 1'b1; keep_head_i = 1'b1; out_ready_i = 1'b1;
      tick();
      flush_i = 1'b0; keep_head_i = 1'b0; out_ready_i = 1'b0;
      check_eq("single_count", count_o, 3'd0);
      check_eq("single_valid", out_valid_o, 1'b0);

      // Reset mid-operation discards queued entries
      push_n(32'h700, 2);
      check_eq("mid_pre", count_o, 3'd2);
      rst = 1'b0;
      #1;
      check_eq("mid_in_ready", in_ready_o, 1'b0);
      check_eq("mid_out_valid", out_valid_o, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      check_eq("mid_count", count_o, 3'd0);
      check_eq("mid_valid_after", out_valid_o, 1'b0);
      check_eq("mid_ready_after", in_ready_o, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
